// File: rtl/apb_requester_arbiter_pkg.sv
// rtl/apb_requester_arbiter_pkg.sv - shared types and default widths for the APB requester arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Index width that stays legal (>= 1 bit) for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_requester_arbiter_rr_priority_select.sv
// rtl/apb_requester_arbiter_rr_priority_select.sv - combinational round-robin winner picker
module rr_priority_select
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    // Scan from the farthest slot back toward rr_ptr so the nearest requester at or after rr_ptr wins.
    always_comb begin
        int slot;
        slot        = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = int'(rr_ptr) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (req[slot]) begin
                grant_idx   = IDW'(slot);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_requester_arbiter.sv
// rtl/apb_requester_arbiter.sv - round-robin N:1 APB requester arbiter; APB_ARB_TIMEOUT_EN adds an access watchdog
module apb_requester_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                s_psel,
    input  logic [NUM_REQ-1:0]                s_penable,
    input  logic [NUM_REQ-1:0]                s_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_pwdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   s_pstrb,
    output logic [NUM_REQ-1:0]                s_pready,
    output logic [DATA_WIDTH-1:0]             s_prdata,
    output logic                              s_pslverr,
    output logic                              m_psel,
    output logic                              m_penable,
    output logic                              m_pwrite,
    output logic [ADDR_WIDTH-1:0]             m_paddr,
    output logic [DATA_WIDTH-1:0]             m_pwdata,
    output logic [DATA_WIDTH/8-1:0]           m_pstrb,
    input  logic                              m_pready,
    input  logic                              m_pslverr,
    input  logic [DATA_WIDTH-1:0]             m_prdata,
`ifdef APB_ARB_TIMEOUT_EN
    output logic                              timeout_flag,
`endif
    output logic [id_width(NUM_REQ)-1:0]      grant_id
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int SW  = DATA_WIDTH / 8;

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] win_idx;
    logic           win_valid;
    logic           timeout_hit;
    logic           done;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_sel (
        .req         (s_psel),
        .rr_ptr      (rr_ptr_q),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    assign timeout_hit = (state_q == ACCESS) && !m_pready && (to_cnt_q == TW'(TIMEOUT_CYCLES));

    // Watchdog: count ACCESS cycles of the current transfer; the flag stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state_d == SETUP) begin
                to_cnt_q <= '0;
            end else if (state_q == ACCESS && to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign done     = (state_q == ACCESS) && (m_pready || timeout_hit);
    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Next-state: one mandatory IDLE cycle between transfers keeps the rotation fair.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response path: route the downstream completion to the granted requester only.
    always_comb begin
        s_pready  = '0;
        s_prdata  = '0;
        s_pslverr = 1'b0;
        if (done) begin
            s_pready  = NUM_REQ'(1) << grant_id;
            s_prdata  = timeout_hit ? '0 : m_prdata;
            s_pslverr = m_pslverr | timeout_hit;
        end
    end

    // State, registered downstream outputs and winner capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_id  <= '0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            m_pstrb   <= '0;
        end else begin
            state_q   <= state_d;
            m_psel    <= (state_d != IDLE);
            m_penable <= (state_d == ACCESS);
            if (state_q == IDLE && win_valid) begin
                grant_id <= win_idx;
                m_pwrite <= s_pwrite[win_idx];
                m_paddr  <= s_paddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                m_pwdata <= s_pwdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                m_pstrb  <= s_pstrb[win_idx*SW +: SW];
            end
            if (done) begin
                rr_ptr_q <= next_ptr;
            end
        end
    end

    // A requester must never raise penable without its psel.
    assert property (@(posedge clk) disable iff (rst) ((s_penable & ~s_psel) == '0));

endmodule

// File: doc/apb_requester_arbiter.md
Name: apb_requester_arbiter

Overview:
- Shares one downstream APB requester port between NUM_REQ upstream APB requesters. Typical requesters: the QSPI management bridge, an Ethernet management path, and a JTAG debug path.
- Round-robin arbitration. A grant is held for a full APB transfer, from SETUP until PREADY.
- Sits between the management bridges and the top-level APB root bridge/decoder.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8)
- ADDR_WIDTH, 16, APB address width
- DATA_WIDTH, 16, APB data width (pstrb width = DATA_WIDTH/8)
- TIMEOUT_CYCLES, 255, watchdog limit; only used when APB_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  single clock; also drives all APB PCLK
- rst  in  1  synchronous active-high reset
- s_psel  in  NUM_REQ  per-requester PSEL
- s_penable  in  NUM_REQ  per-requester PENABLE (checked but not required for grant)
- s_pwrite  in  NUM_REQ  per-requester PWRITE
- s_paddr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_pwdata  in  NUM_REQ*DATA_WIDTH  packed write data
- s_pstrb  in  NUM_REQ*DATA_WIDTH/8  packed strobes
- s_pready  out  NUM_REQ  per-requester PREADY
- s_prdata  out  DATA_WIDTH  shared read data; valid only with the matching s_pready bit
- s_pslverr  out  1  shared error; valid only with an s_pready bit
- m_psel, m_penable, m_pwrite  out  1  downstream control
- m_paddr  out  ADDR_WIDTH  downstream address
- m_pwdata  out  DATA_WIDTH  downstream write data
- m_pstrb  out  DATA_WIDTH/8  downstream strobes
- m_pready, m_pslverr  in  1  downstream response
- m_prdata  in  DATA_WIDTH  downstream read data
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester, for debug

Behaviour:
- Reset:
  - All m_* outputs and s_pready are 0.
  - State is IDLE; rr_ptr = 0; grant_id = 0.
  - Reset mid-transfer aborts silently; no pready is returned to the requester.
- States:
  - IDLE: if any s_psel is set, select the winner by round-robin starting at rr_ptr. Latch the winner's paddr, pwrite, pwdata and pstrb into registers; latch grant_id. Go to SETUP.
  - SETUP: m_psel=1, m_penable=0, registered fields driven. Go to ACCESS.
  - ACCESS: m_psel=1, m_penable=1. Hold until m_pready.
- On m_pready in ACCESS:
  - s_pready[grant_id] = 1 combinationally in the same cycle. s_prdata = m_prdata; s_pslverr = m_pslverr.
  - Next cycle: m_psel=0, state IDLE, rr_ptr = grant_id+1, wrapping to 0 past NUM_REQ-1.
- All m_* outputs are registered; s_pready, s_prdata and s_pslverr are combinational passthrough.
- Latency: a request seen in cycle T gives m_psel in T+1 and m_penable in T+2. Zero-wait-state completion is in T+2.
- IDLE is always spent for at least one cycle between transfers (no back-to-back SETUP). This guarantees fairness.
- Simultaneous requests: the lowest index at or above rr_ptr wins, wrapping around. Losers hold psel and get no pready until served.
- A requester dropping psel while not granted is ignored.
- A requester dropping psel while granted is a protocol violation. The downstream transfer still completes and pready is still pulsed.
- s_prdata and s_pslverr are 0 when no s_pready bit is asserted.
- NUM_REQ=1 degenerates to a one-cycle-delay register slice.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering SETUP and increments in ACCESS.
  - If the counter reaches TIMEOUT_CYCLES without m_pready, the arbiter completes the transfer to the requester with s_pready=1, s_pslverr=1 and s_prdata=0.
  - It then deasserts m_psel next cycle and returns to IDLE.
  - A sticky output port timeout_flag (1 bit) sets on timeout and clears on rst.
- Undefined: no counter and no timeout_flag port; ACCESS waits forever.

Decomposition:
- Package apb_arb_pkg:
  - arb_state_t enum (IDLE, SETUP, ACCESS), logic[1:0].
  - Default width localparams.
- One sub-module, rr_priority_select:
  - Combinational round-robin one-hot/index picker.
  - Inputs: request vector and rr_ptr. Outputs: grant index and valid.

Test Plan:
- Single request: requester 0 reads 0x0010, downstream pready in first ACCESS cycle with prdata=0xBEEF -> m_psel at T+1, s_pready[0] and s_prdata=0xBEEF at T+2, requester 1 never sees pready.
- Contention: both requesters write simultaneously from reset (0x0100 and 0x0200) -> requester 0 served first, then requester 1. The next simultaneous pair serves requester 1 first? No: rr_ptr=0 after serving 1, so requester 0 is first; 100 such pairs give exactly 100 grants each.
- Wait states: downstream holds pready low for 5 cycles -> m_psel/m_penable stable with unchanged paddr/pwdata/pstrb, single s_pready pulse. pslverr=1 from downstream propagates to requester.
- Reset mid-ACCESS: rst asserted on cycle 1 of ACCESS -> next cycle all m_* = 0, no s_pready, a fresh request is granted to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): downstream never readies -> s_pready=1 and s_pslverr=1 after 8 ACCESS cycles, timeout_flag=1, subsequent transfer proceeds normally.
- Strobe passthrough: requester 1 writes pstrb=2'b01, pwdata=0x00AA to 0x0033 -> downstream sees identical fields, grant_id=1.
